charge_acc: RTL

Packet-accounting receiver that sits on the consumer side of the packet-generator handshake (`in_vld`/`in_rdy`) in the charging datapath. It accepts packet descriptors and accumulates per-counter-ID uplink/downlink byte and packet totals in a register table. A request/acknowledge readout port returns any entry, with optional clear-on-read, for the billing side.

---
 rtl/charge_acc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/charge_acc.sv
// charge_acc: packet-accounting receiver for the charging datapath.
//
// It takes packet descriptors over a valid/ready handshake. For each descriptor
// that is charged and in range, it adds the packet to one entry of a counter
// table. The entry holds uplink/downlink byte and packet totals plus the
// timestamp of the last charged packet. A request/acknowledge port lets the
// billing side read any entry, and can clear the entry as part of the read.
//
// Ports
//   asclk, aresetn        clock; synchronous active-low reset
//   in_vld / in_rdy       descriptor handshake
//   in_pkt_id             96-bit packet sequence id (recorded on every accept)
//   in_pkt_len            packet length in bytes
//   in_cnt_id             table index to charge
//   in_cnt_en             1 = charge, 0 = accept without counting
//   in_ul                 1 = uplink, 0 = downlink
//   timer                 free-running timestamp
//   rd_req, rd_id, rd_clr readout request (level), entry index, clear-on-read
//   rd_vld, rd_err        readout valid / index out of range
//   rd_*_bytes, rd_*_pkts, rd_last_ts   readout data
//   stat_drop_cnt         saturating count of out-of-range charged descriptors
//   stat_last_pkt_id      packet id of the most recently accepted descriptor
//   busy                  high whenever the FSM is not idle
//
// state | meaning
// INIT  | clearing the table, one entry per cycle
// IDLE  | accepting descriptors or read requests
// UPD   | adding the latched packet into its entry
// READ  | capturing the requested entry, optional clear
// RESP  | holding readout data until rd_req drops
module charge_acc #(
    parameter int CNT_DEPTH = 16,
    parameter int BYTE_W    = 48,
    parameter int PKT_W     = 32
) (
    input  logic              asclk,
    input  logic              aresetn,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [95:0]       in_pkt_id,
    input  logic [15:0]       in_pkt_len,
    input  logic [13:0]       in_cnt_id,
    input  logic              in_cnt_en,
    input  logic              in_ul,
    input  logic [23:0]       timer,
    input  logic              rd_req,
    input  logic [13:0]       rd_id,
    input  logic              rd_clr,
    output logic              rd_vld,
    output logic              rd_err,
    output logic [BYTE_W-1:0] rd_ul_bytes,
    output logic [BYTE_W-1:0] rd_dl_bytes,
    output logic [PKT_W-1:0]  rd_ul_pkts,
    output logic [PKT_W-1:0]  rd_dl_pkts,
    output logic [23:0]       rd_last_ts,
    output logic [31:0]       stat_drop_cnt,
    output logic [95:0]       stat_last_pkt_id,
    output logic              busy
);

    localparam int IDX_W = (CNT_DEPTH > 1) ? $clog2(CNT_DEPTH) : 1;
    localparam logic [13:0]      DEPTH_ID = 14'(CNT_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CNT_DEPTH - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_UPD, S_READ, S_RESP} state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] ul_bytes;
        logic [BYTE_W-1:0] dl_bytes;
        logic [PKT_W-1:0]  ul_pkts;
        logic [PKT_W-1:0]  dl_pkts;
        logic [23:0]       last_ts;
    } entry_t;

    entry_t table_q [CNT_DEPTH];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [IDX_W-1:0] upd_id_q, upd_id_d;
    logic [15:0]      upd_len_q, upd_len_d;
    logic             upd_ul_q, upd_ul_d;
    logic [23:0]      upd_ts_q, upd_ts_d;
    logic [13:0]      rd_id_lat_q, rd_id_lat_d;
    logic             rd_clr_lat_q, rd_clr_lat_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_err_q, rd_err_d;
    entry_t           rd_data_q, rd_data_d;
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic [95:0]      last_pkt_id_q, last_pkt_id_d;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    entry_t           wr_entry;
    entry_t           cur_entry;

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        upd_id_d      = upd_id_q;
        upd_len_d     = upd_len_q;
        upd_ul_d      = upd_ul_q;
        upd_ts_d      = upd_ts_q;
        rd_id_lat_d   = rd_id_lat_q;
        rd_clr_lat_d  = rd_clr_lat_q;
        rd_vld_d      = rd_vld_q;
        rd_err_d      = rd_err_q;
        rd_data_d     = rd_data_q;
        drop_cnt_d    = drop_cnt_q;
        last_pkt_id_d = last_pkt_id_q;
        in_rdy        = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = init_idx_q;
        wr_entry      = '0;
        cur_entry     = table_q[upd_id_q];

        case (state_q)
            S_INIT: begin
                wr_en  = 1'b1;
                wr_idx = init_idx_q;
                if (init_idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
            S_IDLE: begin
                // A pending read blocks acceptance so the read cannot be starved.
                in_rdy = !rd_req;
                if (rd_req) begin
                    rd_id_lat_d  = rd_id;
                    rd_clr_lat_d = rd_clr;
                    state_d      = S_READ;
                end else if (in_vld) begin
                    last_pkt_id_d = in_pkt_id;
                    if (in_cnt_en) begin
                        if (in_cnt_id >= DEPTH_ID) begin
                            if (drop_cnt_q != 32'hFFFF_FFFF) begin
                                drop_cnt_d = drop_cnt_q + 32'd1;
                            end
                        end else begin
                            upd_id_d  = in_cnt_id[IDX_W-1:0];
                            upd_len_d = in_pkt_len;
                            upd_ul_d  = in_ul;
                            upd_ts_d  = timer;
                            state_d   = S_UPD;
                        end
                    end
                end
            end
            S_UPD: begin
                wr_en    = 1'b1;
                wr_idx   = upd_id_q;
                wr_entry = cur_entry;
                if (upd_ul_q) begin
                    wr_entry.ul_bytes = cur_entry.ul_bytes + BYTE_W'(upd_len_q);
                    wr_entry.ul_pkts  = cur_entry.ul_pkts + PKT_W'(1);
                end else begin
                    wr_entry.dl_bytes = cur_entry.dl_bytes + BYTE_W'(upd_len_q);
                    wr_entry.dl_pkts  = cur_entry.dl_pkts + PKT_W'(1);
                end
                wr_entry.last_ts = upd_ts_q;
                state_d = S_IDLE;
            end
            S_READ: begin
                rd_vld_d = 1'b1;
                if (rd_id_lat_q >= DEPTH_ID) begin
                    rd_data_d = '0;
                    rd_err_d  = 1'b1;
                end else begin
                    rd_data_d = table_q[rd_id_lat_q[IDX_W-1:0]];
                    rd_err_d  = 1'b0;
                    if (rd_clr_lat_q) begin
                        wr_en  = 1'b1;
                        wr_idx = rd_id_lat_q[IDX_W-1:0];
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!rd_req) begin
                    rd_vld_d = 1'b0;
                    rd_err_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            state_q       <= S_INIT;
            init_idx_q    <= '0;
            upd_id_q      <= '0;
            upd_len_q     <= '0;
            upd_ul_q      <= 1'b0;
            upd_ts_q      <= '0;
            rd_id_lat_q   <= '0;
            rd_clr_lat_q  <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= '0;
            drop_cnt_q    <= '0;
            last_pkt_id_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            upd_id_q      <= upd_id_d;
            upd_len_q     <= upd_len_d;
            upd_ul_q      <= upd_ul_d;
            upd_ts_q      <= upd_ts_d;
            rd_id_lat_q   <= rd_id_lat_d;
            rd_clr_lat_q  <= rd_clr_lat_d;
            rd_vld_q      <= rd_vld_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
            drop_cnt_q    <= drop_cnt_d;
            last_pkt_id_q <= last_pkt_id_d;
        end
    end

    // The table has no reset of its own; INIT clears it. Writes are gated
    // during reset so that an update caught by reset is discarded.
    always_ff @(posedge asclk) begin
        if (aresetn && wr_en) begin
            table_q[wr_idx] <= wr_entry;
        end
    end

    assign rd_vld           = rd_vld_q;
    assign rd_err           = rd_err_q;
    assign rd_ul_bytes      = rd_data_q.ul_bytes;
    assign rd_dl_bytes      = rd_data_q.dl_bytes;
    assign rd_ul_pkts       = rd_data_q.ul_pkts;
    assign rd_dl_pkts       = rd_data_q.dl_pkts;
    assign rd_last_ts       = rd_data_q.last_ts;
    assign stat_drop_cnt    = drop_cnt_q;
    assign stat_last_pkt_id = last_pkt_id_q;
    assign busy             = (state_q != S_IDLE);

endmodule
